// File: rtl/demux_pkg.sv
// Shared constants and helpers for the registered 1-to-2 word demultiplexer.
package demux_pkg;

  localparam int WORD_W = 32;
  localparam int CNT_W  = 16;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  // One-hot destination decode: bit 0 is port A, bit 1 is port B.
  function automatic logic [1:0] port_decode(input logic sel);
    logic [1:0] dec;
    dec = 2'b00;
    case (sel)
      PORT_A:  dec = 2'b01;
      PORT_B:  dec = 2'b10;
      default: dec = 2'b00;
    endcase
    return dec;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output register with valid flag and a wrapping count of loads.
module demux_slot #(
  parameter int WIDTH = demux_pkg::WORD_W,
  parameter int CNT_W = demux_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             pop,
  input  logic [WIDTH-1:0] d,
  output logic             valid,
  output logic [WIDTH-1:0] q,
  output logic [CNT_W-1:0] count
);

  logic             r_valid;
  logic [WIDTH-1:0] r_q;
  logic [CNT_W-1:0] r_count;

  // Load wins over pop so a simultaneous pop and load keeps the slot full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_q     <= {WIDTH{1'b0}};
      r_count <= {CNT_W{1'b0}};
    end else if (load) begin
      r_valid <= 1'b1;
      r_q     <= d;
      r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (pop) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_valid;
    end
  end

  assign valid = r_valid;
  assign q     = r_q;
  assign count = r_count;

endmodule

// File: rtl/demux_32bit_reg.sv
// Registered 1-to-2 demultiplexer: steers each accepted word into slot A or B.
module demux_32bit_reg #(
  parameter int WIDTH = demux_pkg::WORD_W,
  parameter int CNT_W = demux_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] a_data,
  output logic [CNT_W-1:0] a_count,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [WIDTH-1:0] b_data,
  output logic [CNT_W-1:0] b_count
);

  import demux_pkg::*;

  logic       w_ready;
  logic       w_accept;
  logic [1:0] w_load;

  // Only the destination slot can stall the producer.
  always_comb begin
    w_ready = 1'b0;
    if (in_sel == PORT_B) begin
      w_ready = ~b_valid | b_ready;
    end else begin
      w_ready = ~a_valid | a_ready;
    end
  end

  assign in_ready = w_ready;
  assign w_accept = in_valid & w_ready;
  assign w_load   = {2{w_accept}} & port_decode(in_sel);

  demux_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot_a (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (w_load[0]),
    .pop   (a_valid & a_ready),
    .d     (in_data),
    .valid (a_valid),
    .q     (a_data),
    .count (a_count)
  );

  demux_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot_b (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (w_load[1]),
    .pop   (b_valid & b_ready),
    .d     (in_data),
    .valid (b_valid),
    .q     (b_data),
    .count (b_count)
  );

endmodule
